// File: rtl/sram_ctrl.sv
// sram_ctrl: single-outstanding request controller for a single-port synchronous SRAM.
// Full-strobe writes go straight to the SRAM. Partial-strobe writes read the old word first,
// merge the enabled bytes into it, and then write it back. Zero-strobe writes respond without
// touching the SRAM.
module sram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_we,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                state_q, state_d;

    // The latched request address is kept directly in the SRAM address register.
    // It only changes on acceptance, so the SRAM address is stable for the whole transaction.
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;

    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

    // The SRAM write-data register also serves as the merge register for partial writes.
    // It is loaded with the merged word in CAP and presented to the SRAM in WR.
    logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic                  sram_we_q, sram_we_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic [DATA_WIDTH-1:0] merge_val;
    logic                  strb_full;
    logic                  strb_zero;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we    = sram_we_q;

    assign strb_full = &req_wstrb;
    assign strb_zero = ~|req_wstrb;

    // Byte merge: enabled bytes come from the latched write data, the rest from the old SRAM word.
    always_comb begin
        merge_val = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            merge_val[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : sram_rdata[8*i +: 8];
        end
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        sram_addr_d  = sram_addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sram_addr_d = req_addr;
                    write_d     = req_write;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    if (!req_write) begin
                        state_d = RD;
                    end else if (strb_full) begin
                        state_d      = WR;
                        sram_we_d    = 1'b1;
                        sram_wdata_d = req_wdata;
                    end else if (strb_zero) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (!write_q) begin
                    resp_rdata_d = sram_rdata;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    sram_wdata_d = merge_val;
                    sram_we_d    = 1'b1;
                    state_d      = WR;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // All controller state and registered outputs, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sram_addr_q  <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            sram_addr_q  <= sram_addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_q    <= sram_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width, a multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_WIDTH  word address.
REQ-009 req_wdata  input  DATA_WIDTH  write data.
REQ-010 req_wstrb  input  STRB_WIDTH  byte enables; bit i covers data bits [8i+7:8i].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  response consumed.
REQ-013 resp_rdata  output  DATA_WIDTH  read data, registered.
REQ-014 sram_addr  output  ADDR_WIDTH  to the single-port SRAM.
REQ-015 sram_wdata  output  DATA_WIDTH  to the SRAM.
REQ-016 sram_we  output  1  SRAM write enable.
REQ-017 sram_rdata  input  DATA_WIDTH  from the SRAM; valid the cycle after a cycle with sram_we=0; not updated during sram_we=1 cycles.

Function
REQ-018 The FSM states SHALL be IDLE, RD, CAP, WR and RESP; only one request SHALL be in flight.
REQ-019 req_ready SHALL be 1 exactly when the state is IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-020 On acceptance the controller SHALL latch addr, write, wdata and wstrb into internal registers; later changes to the req_* inputs SHALL have no effect on the latched request.
REQ-021 Transitions out of IDLE on acceptance:
  - read -> RD;
  - write with wstrb all ones -> WR;
  - write with wstrb zero -> RESP;
  - any other write (partial strobe) -> RD.
REQ-022 RD: sram_addr = latched addr, sram_we = 0; next state CAP.
REQ-023 CAP, for a read: resp_rdata <= sram_rdata; next state RESP.
REQ-024 CAP, for a partial write: merge register <= per byte, wdata byte where the wstrb bit is 1, else the sram_rdata byte; next state WR.
REQ-025 WR: sram_we = 1, sram_addr = latched addr, sram_wdata = latched wdata (full write) or the merge register (partial write); held for exactly one cycle; next state RESP.
REQ-026 RESP: resp_valid = 1; transition to IDLE on the edge where resp_ready = 1; otherwise hold RESP with resp_valid and resp_rdata stable.
REQ-027 sram_we SHALL be 1 only in WR; the SRAM is never written in any other state.
REQ-028 Latency from the accept edge to the first resp_valid cycle:
  - read: 3 cycles;
  - full write: 2 cycles;
  - partial write: 4 cycles;
  - zero-strobe write: 1 cycle.
REQ-029 resp_rdata SHALL change only in CAP for a read; writes leave it unchanged.
REQ-030 With resp_ready tied to 1, back-to-back full writes SHALL sustain one request per 3 cycles, and back-to-back reads one per 4 cycles.
REQ-031 Outside RD and WR, sram_addr SHALL hold the latched addr and sram_wdata SHALL hold its last value, so no spurious SRAM activity is caused.

Reset
REQ-032 While rst_n = 0, the controller SHALL immediately hold:
  - state = IDLE;
  - resp_valid = 0, sram_we = 0;
  - latched addr/wdata/wstrb/write = 0, merge register = 0;
  - resp_rdata = 0, sram_addr = 0, sram_wdata = 0;
  - req_ready = 1, following from IDLE.
REQ-033 Reset asserted mid-operation in any state SHALL abort the transaction with no further sram_we pulse and no response; a write in WR is not guaranteed to complete.

Verification
REQ-034 Full write then read: write addr 0x005, wdata 0xDEADBEEF, wstrb 0xF -> one sram_we pulse 1 cycle after accept; then read addr 0x005 -> resp_rdata 0xDEADBEEF, with resp_valid 3 cycles after accept.
REQ-035 Partial write: memory at 0x010 = 0x11223344, then write wdata 0xAABBCCDD with wstrb 0x5 -> SRAM receives 0x11BB33DD in the WR cycle (accept+3); a following read returns 0x11BB33DD.
REQ-036 Zero strobe: write to 0x020 with wstrb 0x0 -> no sram_we pulse; resp_valid 1 cycle after accept; the memory content is unchanged.
REQ-037 Backpressure: read with resp_ready = 0 held for 5 cycles -> resp_valid stays 1, resp_rdata stays stable, req_ready stays 0; the response completes on the first resp_ready = 1.
REQ-038 Input isolation: change req_addr/req_wdata every cycle after acceptance -> the SRAM access uses only the values latched at acceptance.
REQ-039 Reset mid-RMW: assert rst_n = 0 during CAP of a partial write -> sram_we stays 0, resp_valid = 0, and after release req_ready = 1 and the memory is unchanged.
